imem_dmem_arbiter: RTL

- Shares one memory port between the instruction-fetch requester (fetch buffer prefetch stream) and the data requester (load/store unit).
- Latches single-cycle request pulses so none are lost, and arbitrates between the two requesters.
- Issues one outstanding transaction at a time and routes mem_ready/mem_rdata back to the owning requester.
- Sits between the fetch buffer/LSU and the shared bus/memory controller.

---
 rtl/imem_dmem_arbiter.sv | 171 +++++++++++++++++
 1 files changed

// File: rtl/imem_dmem_arbiter.sv
// ============================================================================
// Module   : imem_dmem_arbiter
// Purpose  : Shares one memory port between instruction fetch and the LSU.
//            Latches request pulses, arbitrates, keeps one transaction in
//            flight and routes the response back to its owner.
//            ARB_ROUND_ROBIN_EN selects round-robin instead of fixed priority.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module imem_dmem_arbiter #(
   parameter int STARVE_LIMIT = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        i_valid,
   input  logic        i_fence,
   input  logic [31:0] i_addr,
   output logic        i_ready,
   output logic [31:0] i_rdata,
   input  logic        d_valid,
   input  logic        d_fence,
   input  logic [31:0] d_addr,
   input  logic [31:0] d_wdata,
   input  logic [3:0]  d_wstrb,
   output logic        d_ready,
   output logic [31:0] d_rdata,
   output logic        mem_valid,
   output logic        mem_fence,
   output logic        mem_instr,
   output logic [31:0] mem_addr,
   output logic [31:0] mem_wdata,
   output logic [3:0]  mem_wstrb,
   input  logic        mem_ready,
   input  logic [31:0] mem_rdata
);

   typedef enum logic [0:0] {
      S_IDLE = 1'b0,
      S_BUSY = 1'b1
   } state_t;

   state_t      r_state;
   logic        r_i_pend;
   logic        r_i_fence;
   logic [31:0] r_i_addr;
   logic        r_d_pend;
   logic        r_d_fence;
   logic [31:0] r_d_addr;
   logic [31:0] r_d_wdata;
   logic [3:0]  r_d_wstrb;

   // An incoming pulse bypasses its slot so an idle port issues on the next edge.
   logic        w_i_req;
   logic        w_i_fence;
   logic [31:0] w_i_addr;
   logic        w_d_req;
   logic        w_d_fence;
   logic [31:0] w_d_addr;
   logic [31:0] w_d_wdata;
   logic [3:0]  w_d_wstrb;
   logic        w_resp;
   logic        w_grant;
   logic        w_pick_i;

   assign w_i_req   = i_valid | r_i_pend;
   assign w_i_fence = i_valid ? i_fence : r_i_fence;
   assign w_i_addr  = i_valid ? i_addr  : r_i_addr;
   assign w_d_req   = d_valid | r_d_pend;
   assign w_d_fence = d_valid ? d_fence : r_d_fence;
   assign w_d_addr  = d_valid ? d_addr  : r_d_addr;
   assign w_d_wdata = d_valid ? d_wdata : r_d_wdata;
   assign w_d_wstrb = d_valid ? d_wstrb : r_d_wstrb;

   assign w_resp  = (r_state == S_BUSY) & mem_ready;
   assign w_grant = ((r_state == S_IDLE) | w_resp) & (w_i_req | w_d_req);

`ifdef ARB_ROUND_ROBIN_EN
   logic r_last_i;

   assign w_pick_i = w_i_req & (~w_d_req | ~r_last_i);

   always_ff @(posedge clk) begin
      if (!rst)
         r_last_i <= 1'b1;
      else if (w_grant)
         r_last_i <= w_pick_i;
   end
`else
   localparam int                c_CNT_W = $clog2(STARVE_LIMIT + 1);
   localparam logic [c_CNT_W-1:0] c_LIMIT = c_CNT_W'(STARVE_LIMIT);

   logic [c_CNT_W-1:0] r_starve;

   assign w_pick_i = w_i_req & (~w_d_req | (r_starve == c_LIMIT));

   always_ff @(posedge clk) begin
      if (!rst)
         r_starve <= '0;
      else if (w_grant) begin
         if (w_pick_i)
            r_starve <= '0;
         else if (w_i_req && (r_starve != c_LIMIT))
            r_starve <= r_starve + 1'b1;
      end
   end
`endif

   always_ff @(posedge clk) begin
      if (!rst) begin
         r_state   <= S_IDLE;
         r_i_pend  <= 1'b0;
         r_i_fence <= 1'b0;
         r_i_addr  <= '0;
         r_d_pend  <= 1'b0;
         r_d_fence <= 1'b0;
         r_d_addr  <= '0;
         r_d_wdata <= '0;
         r_d_wstrb <= '0;
         mem_valid <= 1'b0;
         mem_fence <= 1'b0;
         mem_instr <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
         mem_wstrb <= '0;
      end else begin
         mem_valid <= 1'b0;
         if (i_valid) begin
            r_i_pend  <= 1'b1;
            r_i_fence <= i_fence;
            r_i_addr  <= i_addr;
         end
         if (d_valid) begin
            r_d_pend  <= 1'b1;
            r_d_fence <= d_fence;
            r_d_addr  <= d_addr;
            r_d_wdata <= d_wdata;
            r_d_wstrb <= d_wstrb;
         end
         if (w_resp)
            r_state <= S_IDLE;
         // The winner's slot is consumed even if its pulse arrived this cycle.
         if (w_grant) begin
            r_state   <= S_BUSY;
            mem_valid <= 1'b1;
            mem_instr <= w_pick_i;
            if (w_pick_i) begin
               r_i_pend  <= 1'b0;
               mem_fence <= w_i_fence;
               mem_addr  <= w_i_addr;
               mem_wdata <= '0;
               mem_wstrb <= '0;
            end else begin
               r_d_pend  <= 1'b0;
               mem_fence <= w_d_fence;
               mem_addr  <= w_d_addr;
               mem_wdata <= w_d_wdata;
               mem_wstrb <= w_d_wstrb;
            end
         end
      end
   end

   assign i_ready = w_resp & mem_instr;
   assign d_ready = w_resp & ~mem_instr;
   assign i_rdata = i_ready ? mem_rdata : '0;
   assign d_rdata = d_ready ? mem_rdata : '0;

endmodule

`default_nettype wire
